// File: rtl/mem_bus_arbiter_if.sv
// Handshake bundle between the core's fetch/data ports, the arbiter and the memory bus.
// The master modport is the arbiter's view. It owns the downstream bus and answers both
// requesters. The slave modport is the surrounding core plus the bus.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 18
);
  // Instruction-fetch requester
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_done;
  logic [31:0]       f_rdata;
  // Load/store requester
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_is_write;
  logic [31:0]       d_wdata;
  logic [2:0]        d_num_bytes;
  logic              d_done;
  logic [31:0]       d_rdata;
  // Downstream memory bus
  logic [ADDR_W-1:0] m_target_address;
  logic [2:0]        m_num_bytes;
  logic              m_is_write;
  logic [31:0]       m_write_value;
  logic              m_start_request;
  logic              m_request_done;
  logic [31:0]       m_fetched_value;

  modport master (
    input  f_req, f_addr, d_req, d_addr, d_is_write, d_wdata, d_num_bytes,
    input  m_request_done, m_fetched_value,
    output f_done, f_rdata, d_done, d_rdata,
    output m_target_address, m_num_bytes, m_is_write, m_write_value, m_start_request
  );

  modport slave (
    output f_req, f_addr, d_req, d_addr, d_is_write, d_wdata, d_num_bytes,
    output m_request_done, m_fetched_value,
    input  f_done, f_rdata, d_done, d_rdata,
    input  m_target_address, m_num_bytes, m_is_write, m_write_value, m_start_request
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the fetch and load/store ports.
// A transaction runs IDLE -> GRANT -> RELEASE. Every output is registered.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a GRANT that sees no m_request_done
// within TIMEOUT_CYCLES cycles. The abort returns all-ones data and sets the sticky err.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W         = 18,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_arbiter_if.master bus,
  output logic              owner,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e            state;
  logic              last_owner;   // 0 = fetch, 1 = data
  logic              grant_data;
  logic [ADDR_W-1:0] grant_addr;
  logic              txn_end;
  logic [31:0]       end_rdata;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WdogW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdogW-1:0] WdogLimit = WdogW'(TIMEOUT_CYCLES - 1);

  logic [WdogW-1:0] wdog;
  logic             timeout_hit;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  // Pick the winner in IDLE and decide whether the current GRANT finishes this cycle
  always_comb begin
    // On a tie the port that did not own the bus last time wins
    grant_data = bus.d_req & (~bus.f_req | ~last_owner);
    grant_addr = grant_data ? bus.d_addr : bus.f_addr;
    txn_end    = (state == StGrant) && bus.m_request_done;
    end_rdata  = bus.m_fetched_value;
`ifdef ARB_TIMEOUT_EN
    timeout_hit = (state == StGrant) && !bus.m_request_done && (wdog == WdogLimit);
    if (timeout_hit) begin
      txn_end   = 1'b1;
      end_rdata = 32'hFFFF_FFFF;
    end
`endif
  end

  // Arbitration FSM with all bus and requester outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= StIdle;
      last_owner           <= 1'b1;
      owner                <= 1'b0;
      busy                 <= 1'b0;
      bus.f_done           <= 1'b0;
      bus.f_rdata          <= 32'h0;
      bus.d_done           <= 1'b0;
      bus.d_rdata          <= 32'h0;
      bus.m_target_address <= '0;
      bus.m_num_bytes      <= 3'd0;
      bus.m_is_write       <= 1'b0;
      bus.m_write_value    <= 32'h0;
      bus.m_start_request  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wdog                 <= '0;
      err                  <= 1'b0;
`endif
    end else begin
      bus.f_done <= 1'b0;
      bus.d_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.f_req || bus.d_req) begin
            owner                <= grant_data;
            busy                 <= 1'b1;
            bus.m_target_address <= grant_addr;
            bus.m_num_bytes      <= grant_data ? bus.d_num_bytes : 3'd4;
            bus.m_is_write       <= grant_data & bus.d_is_write;
            bus.m_write_value    <= grant_data ? bus.d_wdata : 32'h0;
            bus.m_start_request  <= 1'b1;
            state                <= StGrant;
`ifdef ARB_TIMEOUT_EN
            wdog                 <= '0;
`endif
          end
        end
        StGrant: begin
          if (txn_end) begin
            bus.m_start_request <= 1'b0;
            if (owner) begin
              bus.d_done  <= 1'b1;
              bus.d_rdata <= end_rdata;
            end else begin
              bus.f_done  <= 1'b1;
              bus.f_rdata <= end_rdata;
            end
            last_owner <= owner;
            state      <= StRelease;
`ifdef ARB_TIMEOUT_EN
            if (timeout_hit) err <= 1'b1;
          end else begin
            wdog <= wdog + WdogW'(1);
`endif
          end
        end
        StRelease: begin
          // The bus lowers done only after start drops; wait for it before re-arbitrating
          if (!bus.m_request_done) begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. The reference model works per transaction:
// round-robin winner, expected bus fields, done and rdata per port, sticky err.
module tb_mem_bus_arbiter;
  localparam int unsigned AW = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic owner, busy, err;

  mem_bus_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_bus_arbiter #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master),
    .owner (owner),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_last_data = 1'b1;
  bit          m_err       = 1'b0;
  logic [31:0] exp_f_rdata = 32'h0;
  logic [31:0] exp_d_rdata = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_data = 1'b1;
    m_err       = 1'b0;
    exp_f_rdata = 32'h0;
    exp_d_rdata = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    bus.m_request_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One transaction: drive requests at an idle negedge, then play the bus.
  // Done rises lat cycles after the grant check and stays high for hold cycles after the pulse.
  // keep=1 leaves the requests untouched, so they act as held levels.
  task automatic run_txn(input bit rf, input bit rd, input logic [AW-1:0] fa,
                         input logic [AW-1:0] da, input bit dw, input logic [31:0] wd,
                         input logic [2:0] nb, input int lat, input int hold,
                         input logic [31:0] rv, input bit keep);
    bit              win_d;
    logic [AW-1:0]   e_addr;
    logic [2:0]      e_nb;
    bit              e_wr;
    bus.f_req       = rf;
    bus.f_addr      = fa;
    bus.d_req       = rd;
    bus.d_addr      = da;
    bus.d_is_write  = dw;
    bus.d_wdata     = wd;
    bus.d_num_bytes = nb;
    win_d  = rd && (!rf || !m_last_data);
    e_addr = win_d ? da : fa;
    e_nb   = win_d ? nb : 3'd4;
    e_wr   = win_d && dw;
    @(negedge clk);
    check_eq("grant_start", 32'(bus.m_start_request), 32'd1);
    check_eq("grant_busy", 32'(busy), 32'd1);
    check_eq("grant_owner", 32'(owner), 32'(win_d));
    check_eq("grant_addr", 32'(bus.m_target_address), 32'(e_addr));
    check_eq("grant_nbytes", 32'(bus.m_num_bytes), 32'(e_nb));
    check_eq("grant_iswrite", 32'(bus.m_is_write), 32'(e_wr));
    if (win_d) check_eq("grant_wdata", bus.m_write_value, wd);
    if (!keep) begin
      bus.f_req       = 1'($urandom);
      bus.d_req       = 1'($urandom);
      bus.f_addr      = AW'($urandom);
      bus.d_addr      = AW'($urandom);
      bus.d_is_write  = 1'($urandom);
      bus.d_wdata     = $urandom;
      bus.d_num_bytes = 3'($urandom);
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check_eq("hold_start", 32'(bus.m_start_request), 32'd1);
      check_eq("hold_addr", 32'(bus.m_target_address), 32'(e_addr));
      check_eq("hold_nbytes", 32'(bus.m_num_bytes), 32'(e_nb));
      check_eq("hold_iswrite", 32'(bus.m_is_write), 32'(e_wr));
      check_eq("hold_dones", {bus.f_done, bus.d_done}, 32'd0);
    end
    bus.m_request_done  = 1'b1;
    bus.m_fetched_value = rv;
    @(negedge clk);
    check_eq("done_start", 32'(bus.m_start_request), 32'd0);
    check_eq("done_pulse", {bus.f_done, bus.d_done}, win_d ? 32'd1 : 32'd2);
    check_eq("done_rdata", win_d ? bus.d_rdata : bus.f_rdata, rv);
    check_eq("done_busy", 32'(busy), 32'd1);
    if (win_d) exp_d_rdata = rv;
    else       exp_f_rdata = rv;
    m_last_data = win_d;
    if (!keep) begin
      bus.f_req = 1'b0;
      bus.d_req = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("rel_dones", {bus.f_done, bus.d_done}, 32'd0);
      check_eq("rel_start", 32'(bus.m_start_request), 32'd0);
      check_eq("rel_busy", 32'(busy), 32'd1);
    end
    bus.m_request_done  = 1'b0;
    bus.m_fetched_value = $urandom;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_start", 32'(bus.m_start_request), 32'd0);
    check_eq("idle_dones", {bus.f_done, bus.d_done}, 32'd0);
    check_eq("idle_f_rdata", bus.f_rdata, exp_f_rdata);
    check_eq("idle_d_rdata", bus.d_rdata, exp_d_rdata);
    check_eq("idle_err", 32'(err), 32'(m_err));
  endtask

  initial begin
    int pat;
    int nsel;
    logic [2:0] nb;
    bus.f_req = 1'b0;
    bus.f_addr = '0;
    bus.d_req = 1'b0;
    bus.d_addr = '0;
    bus.d_is_write = 1'b0;
    bus.d_wdata = 32'h0;
    bus.d_num_bytes = 3'd0;
    bus.m_request_done = 1'b0;
    bus.m_fetched_value = 32'h0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check_eq("rst_start", 32'(bus.m_start_request), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_owner", 32'(owner), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_dones", {bus.f_done, bus.d_done}, 32'd0);
    check_eq("rst_addr", 32'(bus.m_target_address), 32'd0);
    check_eq("rst_rdata", bus.f_rdata | bus.d_rdata, 32'd0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // Stray done while idle is ignored
    bus.m_request_done = 1'b1;
    @(negedge clk);
    check_eq("idle_stray_busy", 32'(busy), 32'd0);
    check_eq("idle_stray_dones", {bus.f_done, bus.d_done}, 32'd0);
    bus.m_request_done = 1'b0;
    @(negedge clk);

    // Single fetch
    run_txn(1'b1, 1'b0, 18'h00010, 18'h0, 1'b0, 32'h0, 3'd0, 4, 0, 32'h0000_0513, 1'b0);
    // Byte store
    run_txn(1'b0, 1'b1, 18'h0, 18'h10004, 1'b1, 32'h1F, 3'd1, 3, 1, 32'hCAFE_0001, 1'b0);

    // Both ports held high after reset: fetch, data, fetch; done lingers 2 cycles on one
    do_reset();
    @(negedge clk);
    run_txn(1'b1, 1'b1, 18'h00100, 18'h20008, 1'b0, 32'h0, 3'd4, 2, 0, 32'h1111_1111, 1'b1);
    run_txn(1'b1, 1'b1, 18'h00100, 18'h20008, 1'b0, 32'h0, 3'd4, 1, 2, 32'h2222_2222, 1'b1);
    run_txn(1'b1, 1'b1, 18'h00100, 18'h20008, 1'b0, 32'h0, 3'd4, 0, 1, 32'h3333_3333, 1'b1);
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset two cycles into GRANT
    bus.f_req = 1'b1;
    bus.f_addr = 18'h00200;
    @(negedge clk);
    check_eq("arst_pre_start", 32'(bus.m_start_request), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_start", 32'(bus.m_start_request), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_dones", {bus.f_done, bus.d_done}, 32'd0);
    bus.f_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_eq("arst_post_dones", {bus.f_done, bus.d_done}, 32'd0);
    check_eq("arst_post_busy", 32'(busy), 32'd0);
    run_txn(1'b0, 1'b1, 18'h0, 18'h00300, 1'b0, 32'h0, 3'd2, 2, 0, 32'h0000_ABCD, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Bus never answers: watchdog aborts after 16 cycles in GRANT
    bus.d_req = 1'b1;
    bus.d_addr = 18'h00400;
    bus.d_is_write = 1'b0;
    bus.d_num_bytes = 3'd4;
    @(negedge clk);
    check_eq("wd_start", 32'(bus.m_start_request), 32'd1);
    bus.d_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_eq("wd_wait_done", 32'(bus.d_done), 32'd0);
      check_eq("wd_wait_start", 32'(bus.m_start_request), 32'd1);
    end
    @(negedge clk);
    check_eq("wd_done", 32'(bus.d_done), 32'd1);
    check_eq("wd_rdata", bus.d_rdata, 32'hFFFF_FFFF);
    check_eq("wd_err", 32'(err), 32'd1);
    check_eq("wd_start_drop", 32'(bus.m_start_request), 32'd0);
    exp_d_rdata = 32'hFFFF_FFFF;
    m_last_data = 1'b1;
    m_err = 1'b1;
    @(negedge clk);
    check_eq("wd_idle_busy", 32'(busy), 32'd0);
    check_eq("wd_err_sticky", 32'(err), 32'd1);
`endif

    // Randomised traffic
    for (int k = 0; k < 40; k++) begin
      pat  = int'($urandom_range(1, 3));
      nsel = int'($urandom_range(0, 2));
      nb   = (nsel == 0) ? 3'd1 : ((nsel == 1) ? 3'd2 : 3'd4);
      run_txn(pat[0], pat[1], AW'($urandom), AW'($urandom), 1'($urandom), $urandom, nb,
              int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), $urandom,
              1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
